// File: rtl/serial_rx_mc.sv
// serial_rx_mc: multi-lane serial capture keyed to a shared 32-bit cnt timebase
// Ports: clk, rst (async, active-high); start arms a capture from idle;
//   a[P_NCH] one serial bit per lane; nbits/n0/n1/msb_first capture config
//   latched on start; cnt shared free-running timebase;
//   busy high while a capture is in flight; data lane k at [k*W +: W];
//   valid one-cycle strobe with data; overrun one-cycle pulse on start while busy.
// Optional: SERIAL_RX_MC_PARITY_EN samples one even-parity bit per lane after
//   the data bits and adds parity_err[P_NCH], registered with data.
module serial_rx_mc #(
  parameter int P_NCH = 4,
  parameter int P_DATA_WIDTH = 64,
  parameter int P_NBITS_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [P_NCH-1:0] a,
  input  logic [P_NBITS_W-1:0] nbits,
  input  logic [31:0] n0,
  input  logic [31:0] n1,
  input  logic msb_first,
  input  logic [31:0] cnt,
  output logic busy,
  output logic [P_NCH*P_DATA_WIDTH-1:0] data,
  output logic valid,
  output logic overrun
`ifdef SERIAL_RX_MC_PARITY_EN
  ,
  output logic [P_NCH-1:0] parity_err
`endif
);
  localparam int W = P_DATA_WIDTH;
  localparam logic [P_NBITS_W-1:0] NB_MAX = P_NBITS_W'(P_DATA_WIDTH);
  localparam logic [P_NBITS_W-1:0] ONE = P_NBITS_W'(1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [31:0] t_next, i_n1;
  logic [P_NBITS_W-1:0] nb, bit_cnt, nb_in;
  logic msb_r, hit, last, take, accept;
  logic [P_NCH-1:0][W-1:0] sr, sr_n;
  assign busy = state != IDLE;
  assign accept = state == IDLE && start;
  assign nb_in = nbits == '0 ? ONE : nbits > NB_MAX ? NB_MAX : nbits;
  assign hit = state == SHIFT && cnt == t_next;
`ifdef SERIAL_RX_MC_PARITY_EN
  logic [P_NCH-1:0] par, perr;
  // The parity bit is the sample after the last data bit and never enters sr.
  assign last = bit_cnt == nb;
  assign take = hit && !last;
  always_comb begin
    perr = '0;
    for (int k = 0; k < P_NCH; k++) perr[k] = ^sr[k] ^ par[k];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= '0;
      parity_err <= '0;
    end else begin
      if (accept) par <= '0;
      else if (hit && last) par <= a;
      if (state == DONE) parity_err <= perr;
    end
  end
`else
  assign last = bit_cnt == nb - ONE;
  assign take = hit;
`endif
  // sr is cleared on start, so the LSB-first indexed write can be an OR.
  always_comb begin
    sr_n = sr;
    for (int k = 0; k < P_NCH; k++)
      sr_n[k] = msb_r ? {sr[k][W-2:0], a[k]} : sr[k] | (W'(a[k]) << bit_cnt);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? SHIFT : IDLE;
      SHIFT: state_n = hit && last ? DONE : SHIFT;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t_next <= '0;
      i_n1 <= '0;
      nb <= '0;
      bit_cnt <= '0;
      msb_r <= 1'b0;
      sr <= '0;
      data <= '0;
      valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      valid <= state == DONE;
      overrun <= start && state != IDLE;
      if (accept) begin
        t_next <= cnt + (n0 == '0 ? 32'd1 : n0);
        i_n1 <= n1 == '0 ? 32'd1 : n1;
        nb <= nb_in;
        msb_r <= msb_first;
        bit_cnt <= '0;
        sr <= '0;
      end
      if (hit) begin
        bit_cnt <= bit_cnt + ONE;
        t_next <= t_next + i_n1;
      end
      if (take) sr <= sr_n;
      if (state == DONE) data <= sr;
    end
  end
endmodule

// File: tb/tb_serial_rx_mc.sv
// tb_serial_rx_mc: directed table-driven bench for serial_rx_mc
module tb_serial_rx_mc;
`ifdef SERIAL_RX_MC_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  logic clk = 1'b0;
  logic rst, start, msb_first, busy, valid, overrun;
  logic [3:0] a;
  logic [7:0] nbits;
  logic [31:0] n0, n1, cnt;
  logic [255:0] data;
`ifdef SERIAL_RX_MC_PARITY_EN
  logic [3:0] parity_err;
`endif
  serial_rx_mc #(.P_NCH(4), .P_DATA_WIDTH(64), .P_NBITS_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .nbits(nbits), .n0(n0), .n1(n1),
    .msb_first(msb_first), .cnt(cnt), .busy(busy), .data(data), .valid(valid),
    .overrun(overrun)
`ifdef SERIAL_RX_MC_PARITY_EN
    , .parity_err(parity_err)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] nbits;
    logic [31:0] n0, n1, c0;
    logic msb;
    logic [3:0][63:0] pat;
    logic [3:0][63:0] exp;
  } vec_t;
  int ntests = 0, nfail = 0;
  // lane driver state: the bench presents bit j of each lane exactly at t0 + j*per,
  // and the complement of the upcoming bit at every other cnt value
  logic active = 1'b0, msb_d;
  logic [31:0] t0, per, nb_e, last_j, dd, q, jj;
  logic [3:0][63:0] pat;
  logic [3:0] par;
  always_comb begin
    a = '0;
    dd = cnt - t0;
    q = dd / per;
    jj = '0;
    for (int k = 0; k < 4; k++) begin
      jj = (dd % per == 0) ? q : q + 1;
      if (active && jj <= last_j)
        a[k] = ((PAR == 1 && jj == last_j) ? par[k] : msb_d ? pat[k][nb_e-1-jj] : pat[k][jj]) ^ (dd % per != 0);
    end
  end
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic vec_t mk(input logic [7:0] nb, input logic [31:0] a0, a1, c, input logic m,
                              input logic [63:0] p0, p1, p2, p3, e0, e1, e2, e3);
    vec_t v;
    v.nbits = nb; v.n0 = a0; v.n1 = a1; v.c0 = c; v.msb = m;
    v.pat[0] = p0; v.pat[1] = p1; v.pat[2] = p2; v.pat[3] = p3;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction
  function automatic int nbe_of(input logic [7:0] nb);
    return nb == 0 ? 1 : nb > 64 ? 64 : int'(nb);
  endfunction
  function automatic logic [3:0] even_par(input vec_t v);
    logic [63:0] m;
    logic [3:0] p;
    m = nbe_of(v.nbits) == 64 ? '1 : (64'd1 << nbe_of(v.nbits)) - 1;
    for (int k = 0; k < 4; k++) p[k] = ^(v.pat[k] & m);
    return p;
  endfunction
  task automatic run(input string tag, input vec_t v, input logic [3:0] pin, input logic [3:0] eperr,
                     input logic poke_en, input logic [31:0] poke_off);
    logic [31:0] n0e, n1e, vcnt;
    bit got;
    n0e = v.n0 == 0 ? 1 : v.n0;
    n1e = v.n1 == 0 ? 1 : v.n1;
    @(negedge clk);
    cnt = v.c0; nbits = v.nbits; n0 = v.n0; n1 = v.n1; msb_first = v.msb; start = 1'b1;
    t0 = v.c0 + n0e; per = n1e; nb_e = nbe_of(v.nbits); last_j = nb_e - 1 + PAR;
    msb_d = v.msb; pat = v.pat; par = pin; active = 1'b1;
    vcnt = t0 + (nb_e - 1 + PAR) * per + 2;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      cnt = cnt + 1;
      start = poke_en && cnt == v.c0 + poke_off;
      if (i == 0) begin
        check({tag, "_busy"}, busy, 1);
        nbits = 8'd3; n0 = 32'd9; n1 = 32'd7; msb_first = ~v.msb;
      end
      if (poke_en && cnt == v.c0 + poke_off + 1) check({tag, "_overrun"}, overrun, 1);
      if (valid) begin
        got = 1;
        check({tag, "_valid_cnt"}, cnt, vcnt);
        for (int k = 0; k < 4; k++) check($sformatf("%s_lane%0d", tag, k), data[k*64 +: 64], v.exp[k]);
`ifdef SERIAL_RX_MC_PARITY_EN
        check({tag, "_parity_err"}, parity_err, eperr);
`endif
      end
    end
    if (!got) check({tag, "_valid_timeout"}, 0, 1);
    @(negedge clk);
    cnt = cnt + 1;
    start = 1'b0;
    check({tag, "_valid_pulse"}, valid, 0);
    check({tag, "_busy_after"}, busy, 0);
    if (poke_en) check({tag, "_overrun_pulse"}, overrun, 0);
    active = 1'b0;
  endtask
  vec_t vt[8];
  initial begin
    bit seen;
    per = 1; t0 = 0; nb_e = 1; last_j = 0; msb_d = 0; pat = '0; par = '0;
    rst = 1'b1; start = 1'b0; cnt = 0; nbits = 0; n0 = 0; n1 = 0; msb_first = 0;
    vt[0] = mk(8, 3, 2, 100, 1, 'hA5, 'h3C, 'hFF, 'h01, 'hA5, 'h3C, 'hFF, 'h01);
    vt[1] = mk(8, 3, 2, 100, 0, 'hA5, 'h3C, 'hFF, 'h01, 'hA5, 'h3C, 'hFF, 'h01);
    vt[2] = mk(4, 'h20, 1, 'hFFFF_FFF0, 1, 'hB, 'h5, 'h0, 'hF, 'hB, 'h5, 'h0, 'hF);
    vt[3] = mk(4, 2, 1, 'hFFFF_FFFC, 0, 'h6, 'h9, 'hC, 'h3, 'h6, 'h9, 'hC, 'h3);
    vt[4] = mk(0, 0, 0, 500, 1, 'h1, 'h2, 'h1, 'h1, 'h1, 'h0, 'h1, 'h1);
    vt[5] = mk(200, 1, 1, 1000, 0, 'hDEAD_BEEF_0123_4567, 'h8000_0000_0000_0001, 'h0, '1,
               'hDEAD_BEEF_0123_4567, 'h8000_0000_0000_0001, 'h0, '1);
    vt[6] = mk(64, 5, 3, 2000, 1, 'h0123_4567_89AB_CDEF, 'hF0F0_F0F0_F0F0_F0F0, 'h5555_5555_5555_5555,
               'h8000_0000_0000_0000, 'h0123_4567_89AB_CDEF, 'hF0F0_F0F0_F0F0_F0F0,
               'h5555_5555_5555_5555, 'h8000_0000_0000_0000);
    vt[7] = mk(2, 1, 4, 3000, 0, 'hFF, 'h2, 'h1, 'hAA, 'h3, 'h2, 'h1, 'h2);
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    check("reset_overrun", overrun, 0);
    check("reset_data", data == '0, 1);
`ifdef SERIAL_RX_MC_PARITY_EN
    check("reset_parity_err", parity_err, 0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run($sformatf("v%0d", i), vt[i], even_par(vt[i]), 4'b0000, 0, 0);
    run("ovr_mid", vt[0], even_par(vt[0]), 4'b0000, 1, 6);
    run("ovr_done", vt[0], even_par(vt[0]), 4'b0000, 1, 18);
    run("par_bad", mk(8, 3, 2, 4000, 1, 'h07, 0, 0, 0, 'h07, 0, 0, 0), 4'b0000, 4'b0001, 0, 0);
    run("par_ok", mk(8, 3, 2, 4000, 1, 'h07, 0, 0, 0, 'h07, 0, 0, 0), 4'b0001, 4'b0000, 0, 0);
    @(negedge clk);
    cnt = 300; nbits = 8; n0 = 3; n1 = 2; msb_first = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cnt = cnt + 1;
    repeat (4) begin
      @(negedge clk);
      cnt = cnt + 1;
    end
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", valid, 0);
    check("rst_mid_data", data == '0, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      cnt = cnt + 1;
      if (valid) seen = 1;
    end
    check("rst_mid_no_valid", seen, 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
